// File: rtl/cache_line_ram.sv
// L1 cache data array: registered 1-cycle reads, byte-enable writes and a critical-word-first
// line-fill sequencer. Define CACHE_LINE_RAM_PARITY_EN to add per-byte even parity.
module cache_line_ram #(
  parameter int WORD_WIDTH     = 32,
  parameter int PORT_WORDS     = 2,
  parameter int WORDS_PER_LINE = 8,
  parameter int NUM_LINES      = 64,
  parameter int ADDR_WIDTH     = 6,
  localparam int GW            = WORD_WIDTH * PORT_WORDS,
  localparam int NB            = GW / 8,
  localparam int BEATS         = WORDS_PER_LINE / PORT_WORDS,
  localparam int OW            = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_index,
  input  logic [OW-1:0]         req_offset,
  input  logic [GW-1:0]         req_wdata,
  input  logic [NB-1:0]         req_be,
  output logic                  rsp_valid,
  output logic [GW-1:0]         rsp_rdata,
  input  logic                  fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_index,
  input  logic [OW-1:0]         fill_offset,
  input  logic                  fill_valid,
  output logic                  fill_ready,
  input  logic [GW-1:0]         fill_data,
  output logic                  fill_busy,
  output logic                  fill_done
`ifdef CACHE_LINE_RAM_PARITY_EN
  ,
  output logic                  parity_err,
  input  logic                  err_inject
`endif
);

  localparam logic [0:0]    IDLE      = 1'b0;
  localparam logic [0:0]    FILL      = 1'b1;
  localparam int            DEPTH     = NUM_LINES * (2 ** OW);
  localparam logic [OW-1:0] LAST_BEAT = OW'(BEATS - 1);

  logic [GW-1:0]            mem_r [DEPTH];
  logic [0:0]               state_r;
  logic [ADDR_WIDTH-1:0]    fill_line_r;
  logic [OW-1:0]            beat_ptr_r;
  logic [OW-1:0]            beat_cnt_r;
  logic                     rsp_valid_r;
  logic [GW-1:0]            rsp_rdata_r;
  logic                     fill_done_r;

  logic                     req_ready_s;
  logic                     req_acc_s;
  logic                     rd_acc_s;
  logic                     fill_acc_s;
  logic                     rd_in_range_s;
  logic [ADDR_WIDTH+OW-1:0] rd_addr_s;
  logic                     wr_en_s;
  logic [ADDR_WIDTH+OW-1:0] wr_addr_s;
  logic [GW-1:0]            wr_data_s;
  logic [NB-1:0]            wr_be_s;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
    return ({1'b0, idx} < (ADDR_WIDTH+1)'(NUM_LINES));
  endfunction

  assign req_ready_s   = (state_r == IDLE) && !fill_start;
  assign req_acc_s     = req_valid && req_ready_s;
  assign rd_acc_s      = req_acc_s && !req_write;
  assign fill_acc_s    = (state_r == FILL) && fill_valid;
  assign rd_addr_s     = {req_index, req_offset};
  assign rd_in_range_s = in_range(req_index);

  assign req_ready  = req_ready_s;
  assign fill_ready = (state_r == FILL);
  assign fill_busy  = (state_r == FILL);
  assign fill_done  = fill_done_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rsp_rdata_r;

`ifdef CACHE_LINE_RAM_PARITY_EN
  logic [NB-1:0] par_mem_r [DEPTH];
  logic          wr_inject_s;
  logic [NB-1:0] wr_par_s;
  logic          parity_err_r;

  function automatic logic [NB-1:0] byte_parity(input logic [GW-1:0] d);
    logic [NB-1:0] p;
    for (int k = 0; k < NB; k++) begin
      p[k] = ^d[8*k +: 8];
    end
    return p;
  endfunction

  assign wr_inject_s = err_inject;
  assign wr_par_s    = byte_parity(wr_data_s) ^ {{(NB-1){1'b0}}, wr_inject_s};
  assign parity_err  = parity_err_r;

  // Parity bits follow their bytes; an injection with byte 0 disabled flips the stored bit.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be_s[k]) begin
          par_mem_r[wr_addr_s][k] <= wr_par_s[k];
        end else if ((k == 0) && wr_inject_s) begin
          par_mem_r[wr_addr_s][k] <= ~par_mem_r[wr_addr_s][k];
        end
      end
    end
  end
`endif

  // Fill beats and access writes never coincide, so they share one array write port.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = '0;
    wr_data_s = '0;
    wr_be_s   = '0;
    if (fill_acc_s) begin
      wr_en_s   = in_range(fill_line_r);
      wr_addr_s = {fill_line_r, beat_ptr_r};
      wr_data_s = fill_data;
      wr_be_s   = '1;
    end else if (req_acc_s && req_write) begin
      wr_en_s   = rd_in_range_s;
      wr_addr_s = rd_addr_s;
      wr_data_s = req_wdata;
      wr_be_s   = req_be;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Array data storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be_s[k]) begin
          mem_r[wr_addr_s][8*k +: 8] <= wr_data_s[8*k +: 8];
        end
      end
    end
  end

  // Read response register: data holds between responses.
  always_ff @(posedge clk) begin
    if (srst) begin
      rsp_valid_r  <= 1'b0;
      rsp_rdata_r  <= '0;
`ifdef CACHE_LINE_RAM_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      rsp_valid_r <= rd_acc_s;
      if (rd_acc_s) begin
        rsp_rdata_r <= rd_in_range_s ? mem_r[rd_addr_s] : '0;
      end
`ifdef CACHE_LINE_RAM_PARITY_EN
      parity_err_r <= rd_acc_s && rd_in_range_s &&
                      (byte_parity(mem_r[rd_addr_s]) != par_mem_r[rd_addr_s]);
`endif
    end
  end

  // Fill sequencer: pointer wraps within the line, counter decides when the line is complete.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r     <= IDLE;
      fill_line_r <= '0;
      beat_ptr_r  <= '0;
      beat_cnt_r  <= '0;
      fill_done_r <= 1'b0;
    end else begin
      fill_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fill_start) begin
            state_r     <= FILL;
            fill_line_r <= fill_index;
            beat_ptr_r  <= fill_offset;
            beat_cnt_r  <= '0;
          end
        end
        FILL: begin
          if (fill_valid) begin
            beat_ptr_r <= (beat_ptr_r == LAST_BEAT) ? '0 : beat_ptr_r + 1'b1;
            beat_cnt_r <= beat_cnt_r + 1'b1;
            if (beat_cnt_r == LAST_BEAT) begin
              state_r     <= IDLE;
              fill_done_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_ram.sv
// Bench for cache_line_ram: plan scenarios plus randomized traffic against a line/beat array
// model. Define CACHE_LINE_RAM_PARITY_EN to include the parity checks.
module tb_cache_line_ram;
  localparam int GW = 64, NB = 8, BEATS = 4, OW = 2, AW = 6, LINES = 64;

  logic clk = 1'b0;
  logic srst, req_valid, req_ready, req_write;
  logic [AW-1:0] req_index;
  logic [OW-1:0] req_offset;
  logic [GW-1:0] req_wdata;
  logic [NB-1:0] req_be;
  logic rsp_valid;
  logic [GW-1:0] rsp_rdata;
  logic fill_start, fill_valid, fill_ready, fill_busy, fill_done;
  logic [AW-1:0] fill_index;
  logic [OW-1:0] fill_offset;
  logic [GW-1:0] fill_data;
`ifdef CACHE_LINE_RAM_PARITY_EN
  logic parity_err, err_inject;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [GW-1:0] ref_mem [LINES][BEATS];
  bit            ref_bad [LINES][BEATS];

  cache_line_ram dut (
    .clk(clk), .srst(srst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_index(req_index), .req_offset(req_offset), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .fill_start(fill_start), .fill_index(fill_index), .fill_offset(fill_offset),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data),
    .fill_busy(fill_busy), .fill_done(fill_done)
`ifdef CACHE_LINE_RAM_PARITY_EN
    , .parity_err(parity_err), .err_inject(err_inject)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_write = 1'b0; req_index = '0; req_offset = '0;
    req_wdata = '0; req_be = '0; fill_start = 1'b0; fill_index = '0; fill_offset = '0;
    fill_valid = 1'b0; fill_data = '0;
`ifdef CACHE_LINE_RAM_PARITY_EN
    err_inject = 1'b0;
`endif
  endtask

  task automatic apply_write(input logic [AW-1:0] idx, input logic [OW-1:0] off,
                             input logic [GW-1:0] data, input logic [NB-1:0] be, input bit inj);
    req_valid = 1'b1; req_write = 1'b1; req_index = idx; req_offset = off;
    req_wdata = data; req_be = be;
`ifdef CACHE_LINE_RAM_PARITY_EN
    err_inject = inj;
`endif
    tick();
    req_valid = 1'b0; req_write = 1'b0;
`ifdef CACHE_LINE_RAM_PARITY_EN
    err_inject = 1'b0;
`endif
    for (int k = 0; k < NB; k++)
      if (be[k]) ref_mem[idx][off][8*k +: 8] = data[8*k +: 8];
    if (be[0]) ref_bad[idx][off] = inj;
    else if (inj) ref_bad[idx][off] = !ref_bad[idx][off];
  endtask

  task automatic apply_read(input logic [AW-1:0] idx, input logic [OW-1:0] off);
    req_valid = 1'b1; req_write = 1'b0; req_index = idx; req_offset = off;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic start_fill(input logic [AW-1:0] idx, input logic [OW-1:0] off);
    fill_start = 1'b1; fill_index = idx; fill_offset = off;
    tick();
    fill_start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    srst = 1'b1;
    tick(); tick();
    srst = 1'b0;
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    vectors++; if (rsp_rdata !== 64'h0) begin miscompares++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    vectors++; if (fill_done !== 1'b0) begin miscompares++; $display("FAIL reset_fill_done got=%b exp=0", fill_done); end
    vectors++; if (fill_busy !== 1'b0) begin miscompares++; $display("FAIL reset_fill_busy got=%b exp=0", fill_busy); end
    vectors++; if (fill_ready !== 1'b0) begin miscompares++; $display("FAIL reset_fill_ready got=%b exp=0", fill_ready); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
`ifdef CACHE_LINE_RAM_PARITY_EN
    vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
`endif
  endtask

  task automatic preload();
    for (int i = 0; i < LINES; i++)
      for (int j = 0; j < BEATS; j++)
        apply_write(AW'(i), OW'(j), {$urandom, $urandom}, 8'hFF, 1'b0);
  endtask

  task automatic test_write_read();
    apply_write(6'd5, 2'd2, 64'h1122334455667788, 8'hFF, 1'b0);
    apply_read(6'd5, 2'd2);
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL wr_rd_valid got=%b exp=1", rsp_valid); end
    vectors++; if (rsp_rdata !== 64'h1122334455667788) begin miscompares++; $display("FAIL wr_rd_data got=%h exp=1122334455667788", rsp_rdata); end
    tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rsp_pulse got=%b exp=0", rsp_valid); end
    vectors++; if (rsp_rdata !== 64'h1122334455667788) begin miscompares++; $display("FAIL rsp_hold got=%h exp=1122334455667788", rsp_rdata); end
    apply_write(6'd5, 2'd2, 64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b0);
    apply_read(6'd5, 2'd2);
    vectors++; if (rsp_rdata !== 64'h11223344BBBBBBBB) begin miscompares++; $display("FAIL partial_be got=%h exp=11223344bbbbbbbb", rsp_rdata); end
    apply_write(6'd5, 2'd2, 64'hDEADBEEFCAFEF00D, 8'h00, 1'b0);
    apply_read(6'd5, 2'd2);
    vectors++; if (rsp_rdata !== 64'h11223344BBBBBBBB) begin miscompares++; $display("FAIL zero_be got=%h exp=11223344bbbbbbbb", rsp_rdata); end
  endtask

  task automatic test_fill();
    logic [GW-1:0] d [BEATS];
    for (int k = 0; k < BEATS; k++) d[k] = {$urandom, $urandom};
    start_fill(6'd9, 2'd3);
    vectors++; if (fill_busy !== 1'b1 || fill_ready !== 1'b1 || req_ready !== 1'b0) begin
      miscompares++; $display("FAIL fill_enter busy/ready/req_ready got=%b%b%b exp=110", fill_busy, fill_ready, req_ready); end
    for (int k = 0; k < BEATS; k++) begin
      if (k == 2) begin
        repeat (2) begin
          tick();
          vectors++; if (fill_done !== 1'b0 || req_ready !== 1'b0 || fill_busy !== 1'b1) begin
            miscompares++; $display("FAIL fill_gap done/req_ready/busy got=%b%b%b exp=001", fill_done, req_ready, fill_busy); end
        end
      end
      fill_valid = 1'b1; fill_data = d[k];
      tick();
      fill_valid = 1'b0;
      if (k < BEATS - 1) begin
        vectors++; if (fill_done !== 1'b0 || req_ready !== 1'b0) begin
          miscompares++; $display("FAIL fill_mid beat=%0d done/req_ready got=%b%b exp=00", k, fill_done, req_ready); end
      end else begin
        vectors++; if (fill_done !== 1'b1 || req_ready !== 1'b1 || fill_busy !== 1'b0) begin
          miscompares++; $display("FAIL fill_last done/req_ready/busy got=%b%b%b exp=110", fill_done, req_ready, fill_busy); end
      end
    end
    tick();
    vectors++; if (fill_done !== 1'b0) begin miscompares++; $display("FAIL fill_done_pulse got=%b exp=0", fill_done); end
    for (int k = 0; k < BEATS; k++) begin
      ref_mem[9][(3 + k) % BEATS] = d[k];
      ref_bad[9][(3 + k) % BEATS] = 1'b0;
    end
    for (int k = 0; k < BEATS; k++) begin
      apply_read(6'd9, OW'((3 + k) % BEATS));
      vectors++; if (rsp_rdata !== d[k]) begin miscompares++; $display("FAIL fill_wrap beat=%0d got=%h exp=%h", k, rsp_rdata, d[k]); end
    end
  endtask

  task automatic test_fill_priority();
    logic [GW-1:0] d;
    fill_start = 1'b1; fill_index = 6'd12; fill_offset = 2'd1;
    req_valid = 1'b1; req_write = 1'b0; req_index = 6'd5; req_offset = 2'd2;
    #1;
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL prio_req_ready got=%b exp=0", req_ready); end
    tick();
    fill_start = 1'b0; req_valid = 1'b0;
    vectors++; if (rsp_valid !== 1'b0 || fill_busy !== 1'b1) begin
      miscompares++; $display("FAIL prio_outcome rsp_valid/busy got=%b%b exp=01", rsp_valid, fill_busy); end
    start_fill(6'd20, 2'd0);
    vectors++; if (fill_busy !== 1'b1) begin miscompares++; $display("FAIL ignored_start busy got=%b exp=1", fill_busy); end
    for (int k = 0; k < BEATS; k++) begin
      d = {$urandom, $urandom};
      fill_valid = 1'b1; fill_data = d;
      tick();
      ref_mem[12][(1 + k) % BEATS] = d;
      ref_bad[12][(1 + k) % BEATS] = 1'b0;
    end
    fill_valid = 1'b0;
    vectors++; if (fill_done !== 1'b1) begin miscompares++; $display("FAIL prio_done got=%b exp=1", fill_done); end
    for (int k = 0; k < BEATS; k++) begin
      apply_read(6'd12, OW'(k));
      vectors++; if (rsp_rdata !== ref_mem[12][k]) begin miscompares++; $display("FAIL prio_line12 off=%0d got=%h exp=%h", k, rsp_rdata, ref_mem[12][k]); end
    end
    apply_read(6'd20, 2'd0);
    vectors++; if (rsp_rdata !== ref_mem[20][0]) begin miscompares++; $display("FAIL prio_line20 got=%h exp=%h", rsp_rdata, ref_mem[20][0]); end
  endtask

  task automatic test_fill_reset();
    logic [GW-1:0] d;
    start_fill(6'd30, 2'd2);
    for (int k = 0; k < 2; k++) begin
      d = {$urandom, $urandom};
      fill_valid = 1'b1; fill_data = d;
      tick();
      ref_mem[30][2 + k] = d;
      ref_bad[30][2 + k] = 1'b0;
    end
    fill_valid = 1'b0;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    vectors++; if (fill_busy !== 1'b0 || fill_done !== 1'b0 || fill_ready !== 1'b0) begin
      miscompares++; $display("FAIL abort busy/done/ready got=%b%b%b exp=000", fill_busy, fill_done, fill_ready); end
    tick();
    vectors++; if (fill_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got=%b exp=0", fill_done); end
    for (int k = 0; k < BEATS; k++) begin
      apply_read(6'd30, OW'(k));
      vectors++; if (rsp_rdata !== ref_mem[30][k]) begin miscompares++; $display("FAIL abort_keep off=%0d got=%h exp=%h", k, rsp_rdata, ref_mem[30][k]); end
    end
    start_fill(6'd31, 2'd0);
    vectors++; if (fill_busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy got=%b exp=1", fill_busy); end
    for (int k = 0; k < BEATS; k++) begin
      d = {$urandom, $urandom};
      fill_valid = 1'b1; fill_data = d;
      tick();
      ref_mem[31][k] = d;
      ref_bad[31][k] = 1'b0;
    end
    fill_valid = 1'b0;
    vectors++; if (fill_done !== 1'b1) begin miscompares++; $display("FAIL restart_done got=%b exp=1", fill_done); end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_write = 1'b0; req_index = 6'd7;
    for (int i = 0; i < BEATS; i++) begin
      req_offset = OW'(i);
      tick();
      vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[7][i]) begin
        miscompares++; $display("FAIL b2b_read off=%0d valid=%b got=%h exp=%h", i, rsp_valid, rsp_rdata, ref_mem[7][i]); end
    end
    req_valid = 1'b0;
    apply_write(6'd7, 2'd0, {$urandom, $urandom}, 8'hFF, 1'b0);
    apply_write(6'd7, 2'd0, {$urandom, $urandom}, 8'hF0, 1'b0);
    apply_read(6'd7, 2'd0);
    vectors++; if (rsp_rdata !== ref_mem[7][0]) begin miscompares++; $display("FAIL b2b_wwr got=%h exp=%h", rsp_rdata, ref_mem[7][0]); end
  endtask

  task automatic test_random();
    logic [AW-1:0] idx;
    logic [OW-1:0] off;
    logic [GW-1:0] d;
    int op;
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 9));
      idx = AW'($urandom_range(0, LINES - 1));
      off = OW'($urandom_range(0, BEATS - 1));
      if (op < 4) begin
        apply_write(idx, off, {$urandom, $urandom},
                    ($urandom_range(0, 7) == 0) ? 8'h00 : NB'($urandom), 1'b0);
      end else if (op < 9) begin
        apply_read(idx, off);
        vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[idx][off]) begin
          miscompares++; $display("FAIL rand_read idx=%0d off=%0d valid=%b got=%h exp=%h", idx, off, rsp_valid, rsp_rdata, ref_mem[idx][off]); end
`ifdef CACHE_LINE_RAM_PARITY_EN
        vectors++; if (parity_err !== ref_bad[idx][off]) begin
          miscompares++; $display("FAIL rand_parity idx=%0d off=%0d got=%b exp=%b", idx, off, parity_err, ref_bad[idx][off]); end
`endif
      end else begin
        start_fill(idx, off);
        for (int k = 0; k < BEATS; k++) begin
          repeat ($urandom_range(0, 2)) tick();
          d = {$urandom, $urandom};
          fill_valid = 1'b1; fill_data = d;
          tick();
          fill_valid = 1'b0;
          ref_mem[idx][(int'(off) + k) % BEATS] = d;
          ref_bad[idx][(int'(off) + k) % BEATS] = 1'b0;
        end
        vectors++; if (fill_done !== 1'b1) begin miscompares++; $display("FAIL rand_fill_done got=%b exp=1", fill_done); end
      end
    end
  endtask

`ifdef CACHE_LINE_RAM_PARITY_EN
  task automatic test_parity();
    apply_write(6'd40, 2'd1, {$urandom, $urandom}, 8'hFF, 1'b1);
    apply_read(6'd40, 2'd1);
    vectors++; if (rsp_valid !== 1'b1 || parity_err !== 1'b1) begin
      miscompares++; $display("FAIL parity_inject valid/err got=%b%b exp=11", rsp_valid, parity_err); end
    vectors++; if (rsp_rdata !== ref_mem[40][1]) begin miscompares++; $display("FAIL parity_data got=%h exp=%h", rsp_rdata, ref_mem[40][1]); end
    tick();
    vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("FAIL parity_idle got=%b exp=0", parity_err); end
    apply_write(6'd40, 2'd1, {$urandom, $urandom}, 8'hFF, 1'b0);
    apply_read(6'd40, 2'd1);
    vectors++; if (rsp_valid !== 1'b1 || parity_err !== 1'b0) begin
      miscompares++; $display("FAIL parity_clean valid/err got=%b%b exp=10", rsp_valid, parity_err); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b0;
    idle_inputs();
    test_reset();
    preload();
    test_write_read();
    test_fill();
    test_fill_priority();
    test_fill_reset();
    test_back_to_back();
`ifdef CACHE_LINE_RAM_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_line_ram.md
Name: cache_line_ram

Overview:
- Next-generation L1 cache data array: one entry per line, each line split into BEATS word groups of PORT_WORDS words.
- Adds to the previous array:
  - registered 1-cycle read with a valid/ready request port
  - byte-enable writes
  - a line-fill sequencer that takes a full refill burst, critical-word-first with wrap-around.
- Sits between the cache controller (access port) and the bus refill path (fill port).

Parameters:
- WORD_WIDTH, 32, bits per word; must be a multiple of 8.
- PORT_WORDS, 2, words per access/beat; GW = WORD_WIDTH*PORT_WORDS.
- WORDS_PER_LINE, 8, words per line; a power of 2 and a multiple of PORT_WORDS. BEATS = WORDS_PER_LINE/PORT_WORDS; OW = log2(BEATS), minimum 1.
- NUM_LINES, 64, number of lines.
- ADDR_WIDTH, 6, line index width; NUM_LINES <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock, all logic on posedge
- srst  in  1  synchronous reset, active-high
- req_valid  in  1  access request
- req_ready  out  1  access accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_index  in  ADDR_WIDTH  line index
- req_offset  in  OW  word-group offset within the line
- req_wdata  in  GW  write data
- req_be  in  GW/8  byte enables; bit k enables byte k
- rsp_valid  out  1  read data valid, 1-cycle pulse
- rsp_rdata  out  GW  read data
- fill_start  in  1  begin a line fill
- fill_index  in  ADDR_WIDTH  line to fill, sampled on an accepted start
- fill_offset  in  OW  first (critical) beat offset
- fill_valid  in  1  refill beat valid
- fill_ready  out  1  beat accepted when fill_valid && fill_ready
- fill_data  in  GW  refill beat
- fill_busy  out  1  sequencer in FILL
- fill_done  out  1  1-cycle pulse after the last beat is written

Behaviour:
- Reset values: rsp_valid=0, rsp_rdata=0, fill_done=0, fill_busy=0, fill_ready=0, state=IDLE, beat counter=0, parity_err=0.
  - Array contents are not cleared.
  - Reset mid-fill aborts the fill: no fill_done, already-written beats stay in the array.
- States: IDLE and FILL.
  - IDLE -> FILL on fill_start. Latch fill_index into the fill line register and fill_offset into the beat pointer; clear the beat counter.
  - FILL -> IDLE on acceptance of beat number BEATS-1.
  - fill_start is ignored while in FILL.
- req_ready = (state==IDLE) && !fill_start. A fill start takes priority over a same-cycle request.
- fill_ready = (state==FILL); fill_busy = (state==FILL).
- Read:
  - An accepted read makes rsp_valid=1 on the next cycle.
  - rsp_rdata = group [req_offset] of line [req_index] as it was after the previous edge.
  - rsp_rdata holds its value while rsp_valid=0.
- Write:
  - An accepted write updates only the enabled bytes at the edge; no response is generated.
  - req_be=0 performs no change.
  - A read accepted the cycle after a write to the same group returns the new data.
- Fill:
  - Each accepted beat writes the full GW bits at group pointer, then pointer = pointer+1 mod BEATS (wrap-around), counter = counter+1.
  - Beats arrive strictly in order; fill_valid gaps stall the sequencer with no timeout.
  - fill_done pulses the cycle after the last beat; req_ready rises in that same cycle.
- Out-of-range index (>= NUM_LINES): writes are dropped, reads return 0.

Optional Feature:
- Macro CACHE_LINE_RAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte, written alongside the byte (write and fill paths).
  - Extra output parity_err (1 bit) is valid with rsp_valid: OR of per-byte mismatches over the read group; 0 otherwise.
  - Extra input err_inject (1 bit): when high during an accepted write or fill beat, stored parity of byte 0 is inverted.
- Undefined: no parity storage; parity_err and err_inject ports do not exist.

Test Plan:
- Reset, then write index 5, offset 2, data 0x1122334455667788, be=0xFF; read it next cycle -> rsp_valid one cycle later, rsp_rdata=0x1122334455667788.
- Partial write be=0x0F, data 0xAAAAAAAA_BBBBBBBB over the previous value -> read returns 0x11223344BBBBBBBB.
- fill_start index 9, offset 3, beats D0..D3 with a 2-cycle fill_valid gap after D1 -> offsets 3,0,1,2 hold D0..D3; fill_done pulses once the cycle after D3; req_ready=0 throughout FILL.
- fill_start and req_valid read in the same cycle -> fill starts, req_ready=0, read is not accepted; a second fill_start during FILL is ignored.
- srst asserted after 2 of 4 beats -> fill_busy=0 and no fill_done; the 2 written groups read back correctly and the next fill_start is accepted.
- Parity enabled: write with err_inject=1, then read -> parity_err=1 with rsp_valid; a clean rewrite of the same group then a read -> parity_err=0.
